iterative_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing 4-bit opcode map.
- Replaces the combinational multiply/divide with an iterative shift-add multiplier and a restoring divider.
- Adds a start/busy/done handshake, a full double-width product, a divide remainder and divide-by-zero detection.
- Sits between the accumulator/MBR operand path and the accumulator write-back in the CPU datapath.

---
 rtl/iterative_alu.sv | 201 ++++++++++++++++++++
 tb/tb_iterative_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add multiply and restoring divide.
// Optional {C,V,N,Z} flags output is built only when ALU_FLAGS_EN is defined.
module iterative_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, ITER = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             is_div_r;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] sc_res_s;
    logic [WIDTH-1:0] sc_hi_s;
    logic             sc_dbz_s;
    logic             iter_op_s;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH-1:0] step_acc_s;
    logic [WIDTH-1:0] step_lo_s;

    // Single-cycle result and classification of the requested opcode
    always_comb begin
        sc_res_s  = ZERO_W;
        sc_hi_s   = ZERO_W;
        sc_dbz_s  = 1'b0;
        iter_op_s = 1'b0;
        case (opcode)
            4'h0: sc_res_s = operand1 + operand2;
            4'h1: sc_res_s = operand1 - operand2;
            4'h2: iter_op_s = 1'b1;
            4'h3: begin
                if (operand2 == ZERO_W) begin
                    sc_res_s = ONES_W;
                    sc_hi_s  = operand1;
                    sc_dbz_s = 1'b1;
                end else begin
                    iter_op_s = 1'b1;
                end
            end
            4'h4: sc_res_s = {operand1[WIDTH-2:0], 1'b0};
            4'h5: sc_res_s = {1'b0, operand1[WIDTH-1:1]};
            4'h6: sc_res_s = {operand1[WIDTH-2:0], operand1[WIDTH-1]};
            4'h7: sc_res_s = {operand1[0], operand1[WIDTH-1:1]};
            4'h8: sc_res_s = operand1 & operand2;
            4'h9: sc_res_s = operand1 | operand2;
            4'hA: sc_res_s = operand1 ^ operand2;
            4'hB: sc_res_s = ~(operand1 | operand2);
            4'hC: sc_res_s = ~(operand1 & operand2);
            4'hD: sc_res_s = ~(operand1 ^ operand2);
            4'hE: sc_res_s = (operand1 > operand2) ? ONE_W : ZERO_W;
            4'hF: sc_res_s = (operand1 == operand2) ? ONE_W : ZERO_W;
            default: sc_res_s = ZERO_W;
        endcase
    end

    // One iteration step: acc_r holds the partial product high half / partial remainder,
    // lo_r holds the multiplier being shifted out / dividend being replaced by quotient bits
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_W});
        div_shift_s = {acc_r, lo_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (div_trial_s[WIDTH]) begin
                step_acc_s = div_shift_s[WIDTH-1:0];
                step_lo_s  = {lo_r[WIDTH-2:0], 1'b0};
            end else begin
                step_acc_s = div_trial_s[WIDTH-1:0];
                step_lo_s  = {lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_acc_s = mul_sum_s[WIDTH:1];
            step_lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

`ifdef ALU_FLAGS_EN
    logic       sc_c_s;
    logic       sc_v_s;
    logic [3:0] sc_flags_s;
    logic [3:0] it_flags_s;

    // Flag generation; carry/borrow derived by magnitude compare to avoid a wide adder copy
    always_comb begin
        sc_c_s = 1'b0;
        sc_v_s = 1'b0;
        case (opcode)
            4'h0: begin
                sc_c_s = (sc_res_s < operand1);
                sc_v_s = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sc_res_s[WIDTH-1] != operand1[WIDTH-1]);
            end
            4'h1: begin
                sc_c_s = (operand1 < operand2);
                sc_v_s = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (sc_res_s[WIDTH-1] != operand1[WIDTH-1]);
            end
            4'h4: sc_c_s = operand1[WIDTH-1];
            4'h5: sc_c_s = operand1[0];
            default: begin
                sc_c_s = 1'b0;
                sc_v_s = 1'b0;
            end
        endcase
        sc_flags_s = {sc_c_s, sc_v_s, sc_res_s[WIDTH-1], (sc_res_s == ZERO_W)};
        it_flags_s = {(!is_div_r) && (step_acc_s != ZERO_W), 1'b0, step_lo_s[WIDTH-1], (step_lo_s == ZERO_W)};
    end
`endif

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            is_div_r    <= 1'b0;
            opnd_r      <= ZERO_W;
            acc_r       <= ZERO_W;
            lo_r        <= ZERO_W;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= ZERO_W;
            result_hi   <= ZERO_W;
            div_by_zero <= 1'b0;
`ifdef ALU_FLAGS_EN
            flags       <= 4'b0000;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (iter_op_s) begin
                            state_r  <= ITER;
                            busy     <= 1'b1;
                            cnt_r    <= CNT_LOAD;
                            is_div_r <= (opcode == 4'h3);
                            opnd_r   <= operand2;
                            lo_r     <= operand1;
                            acc_r    <= ZERO_W;
                        end else begin
                            done        <= 1'b1;
                            result      <= sc_res_s;
                            result_hi   <= sc_hi_s;
                            div_by_zero <= sc_dbz_s;
`ifdef ALU_FLAGS_EN
                            flags       <= sc_flags_s;
`endif
                        end
                    end
                end
                ITER: begin
                    acc_r <= step_acc_s;
                    lo_r  <= step_lo_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r     <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        result      <= step_lo_s;
                        result_hi   <= step_acc_s;
                        div_by_zero <= 1'b0;
`ifdef ALU_FLAGS_EN
                        flags       <= it_flags_s;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu (WIDTH=16): directed vectors, expected results queued at issue,
// a negedge monitor pops and compares on every done pulse.
module tb_iterative_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  opcode;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic        div_by_zero;
`ifdef ALU_FLAGS_EN
    logic [3:0]  flags;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] hi;
        logic        dbz;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    iterative_alu #(.WIDTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .opcode(opcode),
        .operand1(operand1),
        .operand2(operand2),
        .busy(busy),
        .done(done),
        .result(result),
        .result_hi(result_hi),
        .div_by_zero(div_by_zero)
`ifdef ALU_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            check("busy_with_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", {16'd0, result}, {16'd0, e.res});
                check("result_hi", {16'd0, result_hi}, {16'd0, e.hi});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
`ifdef ALU_FLAGS_EN
                check("flags", {28'd0, flags}, {28'd0, e.flg});
`endif
            end
        end
    end

    // Issue one op, scramble inputs after accept, measure latency and busy cycles
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [15:0] eh, input logic ed,
                          input logic [3:0] ef, input int lat, input int intr_cycle, input bit b2b);
        int n;
        int busy_n;
        exp_t e;
        if (!b2b) @(negedge clk);
        start    = 1'b1;
        opcode   = op;
        operand1 = a;
        operand2 = b;
        e.res = er; e.hi = eh; e.dbz = ed; e.flg = ef;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        operand1 = ~a;
        operand2 = ~b;
        n        = 1;
        busy_n   = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_n++;
            start = (intr_cycle != 0) && (n == intr_cycle);
            if (start) begin
                opcode   = 4'h0;
                operand1 = 16'h0001;
                operand2 = 16'h0001;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", n, lat);
        check("busy_cycles", busy_n, lat - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 4'h0; operand1 = 16'h0000; operand2 = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_result_hi", {16'd0, result_hi}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;

        run_op(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 4'b1001, 1, 0, 1'b0);
        run_op(4'h2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 4'b1000, 17, 0, 1'b0);
        run_op(4'h3, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 4'b0000, 17, 0, 1'b0);
        run_op(4'h3, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 4'b0010, 1, 0, 1'b0);

        // Asynchronous reset in cycle 8 of a divide: outputs clear at once, no done follows
        @(negedge clk);
        start = 1'b1; opcode = 4'h3; operand1 = 16'd1000; operand2 = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", {16'd0, result}, 32'd0);
        check("arst_result_hi", {16'd0, result_hi}, 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);
        run_op(4'hA, 16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 1'b0, 4'b0000, 1, 0, 1'b0);

        // Start during busy is ignored
        run_op(4'h2, 16'd3, 16'd4, 16'd12, 16'd0, 1'b0, 4'b0000, 17, 5, 1'b0);

        // Back-to-back: add issued in the cycle the multiply's done is high
        run_op(4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 4'b1000, 17, 0, 1'b0);
        run_op(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 4'b0110, 1, 0, 1'b1);

        run_op(4'h1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 4'b1010, 1, 0, 1'b0);
        run_op(4'h4, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 1'b0, 4'b1000, 1, 0, 1'b0);
        run_op(4'h5, 16'h0003, 16'h0000, 16'h0001, 16'h0000, 1'b0, 4'b1000, 1, 0, 1'b0);
        run_op(4'h6, 16'h8001, 16'h0000, 16'h0003, 16'h0000, 1'b0, 4'b0000, 1, 0, 1'b0);
        run_op(4'h7, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 1'b0, 4'b0010, 1, 0, 1'b0);
        run_op(4'h8, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0, 4'b0000, 1, 0, 1'b0);
        run_op(4'h9, 16'hF000, 16'h000F, 16'hF00F, 16'h0000, 1'b0, 4'b0010, 1, 0, 1'b0);
        run_op(4'hB, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 4'b0010, 1, 0, 1'b0);
        run_op(4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 4'b0001, 1, 0, 1'b0);
        run_op(4'hD, 16'h00FF, 16'h0F0F, 16'hF00F, 16'h0000, 1'b0, 4'b0010, 1, 0, 1'b0);
        run_op(4'hE, 16'd5, 16'd3, 16'd1, 16'h0000, 1'b0, 4'b0000, 1, 0, 1'b0);
        run_op(4'hE, 16'd3, 16'd5, 16'd0, 16'h0000, 1'b0, 4'b0001, 1, 0, 1'b0);
        run_op(4'hF, 16'd7, 16'd7, 16'd1, 16'h0000, 1'b0, 4'b0000, 1, 0, 1'b0);
        run_op(4'hF, 16'd7, 16'd8, 16'd0, 16'h0000, 1'b0, 4'b0001, 1, 0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
